// File: rtl/player_move_ctrl.sv
// player_move_ctrl: one-at-a-time movement sequencer that reads the target
// tile, hands it to the interaction stage and commits the resolved state.
module player_move_ctrl #(
  parameter int MAP_W       = 13,
  parameter int MAP_H       = 13,
  parameter int FLOOR_BITS  = 4,
  parameter int INIT_X      = 6,
  parameter int INIT_Y      = 12,
  parameter int INIT_FLOOR  = 0,
  parameter int INIT_HEALTH = 100
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  move_valid,
  input  logic [1:0]            move_dir,
  output logic                  move_ready,
  output logic                  move_done,
  output logic                  move_blocked,
  output logic [FLOOR_BITS+7:0] map_addr,
  input  logic [15:0]           map_rd_data,
  output logic                  map_we,
  output logic [15:0]           map_wr_data,
  output logic [3:0]            mt_pos_x,
  output logic [3:0]            mt_pos_y,
  output logic [15:0]           mt_floor,
  output logic [3:0]            mt_player_x,
  output logic [3:0]            mt_player_y,
  output logic [31:0]           mt_key_num,
  output logic [15:0]           mt_health,
  output logic [15:0]           mt_tile_id,
  input  logic [15:0]           mt_floor_out,
  input  logic [3:0]            mt_goto_x,
  input  logic [3:0]            mt_goto_y,
  input  logic [31:0]           mt_key_num_out,
  input  logic [15:0]           mt_health_out,
  input  logic [15:0]           mt_new_tile_id,
  output logic [3:0]            player_x,
  output logic [3:0]            player_y,
  output logic [15:0]           floor,
  output logic [31:0]           key_num,
  output logic [15:0]           health
);

  localparam int AW = FLOOR_BITS + 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_LATCH,
    S_EVAL,
    S_WB
  } state_t;

  state_t        state_q;

  logic [3:0]    px_q;
  logic [3:0]    py_q;
  logic [15:0]   floor_q;
  logic [31:0]   key_q;
  logic [15:0]   hp_q;

  logic [3:0]    tgt_x_q;
  logic [3:0]    tgt_y_q;
  logic [AW-1:0] map_addr_q;
  logic [AW-1:0] wb_addr_q;
  logic [15:0]   tile_q;

  logic [15:0]   res_floor_q;
  logic [3:0]    res_x_q;
  logic [3:0]    res_y_q;
  logic [31:0]   res_key_q;
  logic [15:0]   res_hp_q;
  logic [15:0]   res_tile_q;

  logic          done_q;
  logic          blocked_q;
  logic          we_q;
  logic [15:0]   wdata_q;

  logic [4:0]    tgt_x_d;
  logic [4:0]    tgt_y_d;
  logic          oob_d;
  logic          wr_need_d;
  logic          same_cell_d;

  // Target cell in 5-bit arithmetic; a step below 0 wraps to 31 and so
  // lands in the same ">= size" test as a step past the far edge.
  always_comb begin
    tgt_x_d = {1'b0, px_q};
    tgt_y_d = {1'b0, py_q};
    unique case (move_dir)
      2'd0: tgt_y_d = {1'b0, py_q} - 5'd1;
      2'd1: tgt_y_d = {1'b0, py_q} + 5'd1;
      2'd2: tgt_x_d = {1'b0, px_q} - 5'd1;
      2'd3: tgt_x_d = {1'b0, px_q} + 5'd1;
    endcase
    oob_d = ({27'd0, tgt_x_d} >= 32'(MAP_W))
         || ({27'd0, tgt_y_d} >= 32'(MAP_H));
  end

  // Resolved-result comparisons made while the interaction stage settles.
  always_comb begin
    wr_need_d   = (mt_new_tile_id != tile_q);
    same_cell_d = (mt_goto_x == px_q)
               && (mt_goto_y == py_q)
               && (mt_floor_out == floor_q);
  end

  // Sequencer FSM with every output and architectural register owned here.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      px_q        <= 4'(INIT_X);
      py_q        <= 4'(INIT_Y);
      floor_q     <= 16'(INIT_FLOOR);
      key_q       <= '0;
      hp_q        <= 16'(INIT_HEALTH);
      tgt_x_q     <= '0;
      tgt_y_q     <= '0;
      map_addr_q  <= '0;
      wb_addr_q   <= '0;
      tile_q      <= '0;
      res_floor_q <= '0;
      res_x_q     <= '0;
      res_y_q     <= '0;
      res_key_q   <= '0;
      res_hp_q    <= '0;
      res_tile_q  <= '0;
      done_q      <= 1'b0;
      blocked_q   <= 1'b0;
      we_q        <= 1'b0;
      wdata_q     <= '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          done_q    <= 1'b0;
          blocked_q <= 1'b0;
          if (move_valid) begin
            if (oob_d) begin
              done_q    <= 1'b1;
              blocked_q <= 1'b1;
            end else begin
              tgt_x_q    <= tgt_x_d[3:0];
              tgt_y_q    <= tgt_y_d[3:0];
              map_addr_q <= {floor_q[FLOOR_BITS-1:0],
                             tgt_y_d[3:0], tgt_x_d[3:0]};
              state_q    <= S_RD;
            end
          end
        end
        S_RD: begin
          wb_addr_q <= map_addr_q;
          state_q   <= S_LATCH;
        end
        S_LATCH: begin
          tile_q  <= map_rd_data;
          state_q <= S_EVAL;
        end
        S_EVAL: begin
          res_floor_q <= mt_floor_out;
          res_x_q     <= mt_goto_x;
          res_y_q     <= mt_goto_y;
          res_key_q   <= mt_key_num_out;
          res_hp_q    <= mt_health_out;
          res_tile_q  <= mt_new_tile_id;
          we_q        <= wr_need_d;
          wdata_q     <= wr_need_d ? mt_new_tile_id : 16'd0;
          map_addr_q  <= wb_addr_q;
          done_q      <= 1'b1;
          blocked_q   <= same_cell_d;
          state_q     <= S_WB;
        end
        S_WB: begin
          px_q      <= res_x_q;
          py_q      <= res_y_q;
          floor_q   <= res_floor_q;
          key_q     <= res_key_q;
          hp_q      <= res_hp_q;
          we_q      <= 1'b0;
          wdata_q   <= '0;
          done_q    <= 1'b0;
          blocked_q <= 1'b0;
          state_q   <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign move_ready   = (state_q == S_IDLE);
  assign move_done    = done_q;
  assign move_blocked = blocked_q;
  assign map_addr     = map_addr_q;
  assign map_we       = we_q;
  assign map_wr_data  = wdata_q;

  assign mt_pos_x    = tgt_x_q;
  assign mt_pos_y    = tgt_y_q;
  assign mt_floor    = floor_q;
  assign mt_player_x = px_q;
  assign mt_player_y = py_q;
  assign mt_key_num  = key_q;
  assign mt_health   = hp_q;
  assign mt_tile_id  = tile_q;

  // The retiring move's results are shown in the same cycle as move_done;
  // the architectural registers take them on the way back to IDLE so the
  // mt_* view stays stable through WB.
  assign player_x = (state_q == S_WB) ? res_x_q     : px_q;
  assign player_y = (state_q == S_WB) ? res_y_q     : py_q;
  assign floor    = (state_q == S_WB) ? res_floor_q : floor_q;
  assign key_num  = (state_q == S_WB) ? res_key_q   : key_q;
  assign health   = (state_q == S_WB) ? res_hp_q    : hp_q;

  logic unused_res_tile;
  assign unused_res_tile = ^res_tile_q;

endmodule

// File: tb/tb_player_move_ctrl.sv
// tb_player_move_ctrl: map RAM + interaction stage environment and a
// scoreboard of predicted move outcomes for player_move_ctrl.
module tb_player_move_ctrl;

  localparam logic [15:0] T_GROUND = 16'h0001;
  localparam logic [15:0] T_WALL   = 16'h0002;
  localparam logic [15:0] T_KEY0   = 16'h0011;
  localparam logic [15:0] T_KEY1   = 16'h0012;
  localparam logic [15:0] T_STAIR1 = 16'h0020;
  localparam logic [15:0] T_DOOR0  = 16'h0030;
  localparam logic [15:0] T_TRAP   = 16'h0040;
  localparam logic [3:0]  UP_X     = 4'd3;
  localparam logic [3:0]  UP_Y     = 4'd4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic move_valid = 1'b0;
  logic [1:0] move_dir = 2'd0;
  logic move_ready, move_done, move_blocked;
  logic [11:0] map_addr;
  logic [15:0] map_rd_data;
  logic map_we;
  logic [15:0] map_wr_data;
  logic [3:0] mt_pos_x, mt_pos_y, mt_player_x, mt_player_y;
  logic [15:0] mt_floor, mt_health, mt_tile_id;
  logic [31:0] mt_key_num;
  logic [15:0] mt_floor_out, mt_health_out, mt_new_tile_id;
  logic [3:0] mt_goto_x, mt_goto_y;
  logic [31:0] mt_key_num_out;
  logic [3:0] player_x, player_y;
  logic [15:0] floor, health;
  logic [31:0] key_num;

  int n_pass = 0;
  int n_chk = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  player_move_ctrl dut (
    .clk(clk), .rst(rst),
    .move_valid(move_valid), .move_dir(move_dir),
    .move_ready(move_ready), .move_done(move_done),
    .move_blocked(move_blocked),
    .map_addr(map_addr), .map_rd_data(map_rd_data),
    .map_we(map_we), .map_wr_data(map_wr_data),
    .mt_pos_x(mt_pos_x), .mt_pos_y(mt_pos_y),
    .mt_floor(mt_floor), .mt_player_x(mt_player_x),
    .mt_player_y(mt_player_y), .mt_key_num(mt_key_num),
    .mt_health(mt_health), .mt_tile_id(mt_tile_id),
    .mt_floor_out(mt_floor_out), .mt_goto_x(mt_goto_x),
    .mt_goto_y(mt_goto_y), .mt_key_num_out(mt_key_num_out),
    .mt_health_out(mt_health_out), .mt_new_tile_id(mt_new_tile_id),
    .player_x(player_x), .player_y(player_y), .floor(floor),
    .key_num(key_num), .health(health)
  );

  logic [15:0] mem [0:4095];

  always @(posedge clk) begin
    map_rd_data <= mem[map_addr];
    if (map_we) mem[map_addr] <= map_wr_data;
  end

  typedef struct packed {
    logic [15:0] fl;
    logic [3:0]  gx;
    logic [3:0]  gy;
    logic [31:0] key;
    logic [15:0] hp;
    logic [15:0] nt;
  } res_t;

  function automatic res_t resolve(input logic [15:0] t,
      input logic [3:0] px, input logic [3:0] py,
      input logic [3:0] tx, input logic [3:0] ty,
      input logic [15:0] fl, input logic [31:0] k,
      input logic [15:0] hp);
    res_t r;
    r.fl = fl; r.gx = tx; r.gy = ty; r.key = k; r.hp = hp; r.nt = t;
    case (t)
      T_WALL: begin r.gx = px; r.gy = py; end
      T_KEY0: begin r.key = k + 32'd1; r.nt = T_GROUND; end
      T_KEY1: begin r.key = k + 32'h100; r.nt = T_GROUND; end
      T_STAIR1: begin r.fl = fl + 16'd1; r.gx = UP_X; r.gy = UP_Y; end
      T_DOOR0: begin
        if (k[7:0] != 8'd0) begin r.key = k - 32'd1; r.nt = T_GROUND; end
        else begin r.gx = px; r.gy = py; end
      end
      T_TRAP: r.hp = hp - 16'd30;
      default: ;
    endcase
    return r;
  endfunction

  res_t stage;
  always_comb begin
    stage = resolve(mt_tile_id, mt_player_x, mt_player_y, mt_pos_x,
                    mt_pos_y, mt_floor, mt_key_num, mt_health);
  end
  assign mt_floor_out   = stage.fl;
  assign mt_goto_x      = stage.gx;
  assign mt_goto_y      = stage.gy;
  assign mt_key_num_out = stage.key;
  assign mt_health_out  = stage.hp;
  assign mt_new_tile_id = stage.nt;

  typedef struct packed {
    logic        blk;
    logic [3:0]  x;
    logic [3:0]  y;
    logic [15:0] fl;
    logic [31:0] key;
    logic [15:0] hp;
    logic        we;
    logic [11:0] addr;
    logic [15:0] wd;
    int          lat;
  } exp_t;

  typedef struct packed {
    logic        blk;
    logic [3:0]  x;
    logic [3:0]  y;
    logic [15:0] fl;
    logic [31:0] key;
    logic [15:0] hp;
    logic        we;
    logic [11:0] addr;
    logic [15:0] wd;
    int          lat;
    logic [11:0] rd_addr;
    int          we_cnt;
    int          done_cyc;
  } obs_t;

  exp_t sb [$];
  logic [3:0]  e_x;
  logic [3:0]  e_y;
  logic [15:0] e_fl;
  logic [31:0] e_key;
  logic [15:0] e_hp;

  task automatic model_reset();
    e_x = 4'd6; e_y = 4'd12; e_fl = 16'd0; e_key = 32'd0; e_hp = 16'd100;
    sb.delete();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic predict(input logic [1:0] d);
    exp_t e;
    res_t r;
    int tx, ty;
    logic [11:0] a;
    logic [15:0] t;
    tx = int'(e_x); ty = int'(e_y);
    case (d)
      2'd0: ty = ty - 1;
      2'd1: ty = ty + 1;
      2'd2: tx = tx - 1;
      default: tx = tx + 1;
    endcase
    e = '0;
    if (tx < 0 || tx >= 13 || ty < 0 || ty >= 13) begin
      e.blk = 1'b1; e.lat = 1;
    end else begin
      a = {e_fl[3:0], 4'(ty), 4'(tx)};
      t = mem[a];
      r = resolve(t, e_x, e_y, 4'(tx), 4'(ty), e_fl, e_key, e_hp);
      e.blk = (r.gx == e_x) && (r.gy == e_y) && (r.fl == e_fl);
      e.we = (r.nt != t); e.addr = a; e.wd = e.we ? r.nt : 16'd0;
      e.lat = 4;
      e_x = r.gx; e_y = r.gy; e_fl = r.fl; e_key = r.key; e_hp = r.hp;
    end
    e.x = e_x; e.y = e_y; e.fl = e_fl; e.key = e_key; e.hp = e_hp;
    sb.push_back(e);
  endtask

  task automatic issue(input logic [1:0] d, output obs_t o);
    int w;
    int c;
    o = '0;
    w = 0;
    move_dir = d;
    move_valid = 1'b1;
    while (!move_ready && w < 20) begin @(posedge clk); #1; w++; end
    @(posedge clk); #1;
    move_valid = 1'b0;
    o.rd_addr = map_addr;
    o.we_cnt = int'(map_we);
    c = 1;
    while (!move_done && c < 12) begin
      @(posedge clk); #1;
      c++;
      o.we_cnt += int'(map_we);
    end
    o.lat = c; o.done_cyc = cyc;
    o.blk = move_blocked; o.x = player_x; o.y = player_y; o.fl = floor;
    o.key = key_num; o.hp = health; o.we = map_we; o.addr = map_addr;
    o.wd = map_wr_data;
    @(posedge clk); #1;
    o.we_cnt += int'(map_we);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    if (move_ready !== 1'b1) $display("FAIL rst_ready got %0b want 1", move_ready); else n_pass++; n_chk++;
    if (move_done !== 1'b0) $display("FAIL rst_done got %0b want 0", move_done); else n_pass++; n_chk++;
    if (move_blocked !== 1'b0) $display("FAIL rst_blk got %0b want 0", move_blocked); else n_pass++; n_chk++;
    if (map_we !== 1'b0) $display("FAIL rst_we got %0b want 0", map_we); else n_pass++; n_chk++;
    if (map_addr !== 12'h000) $display("FAIL rst_addr got %0h want 0", map_addr); else n_pass++; n_chk++;
    if (map_wr_data !== 16'h0) $display("FAIL rst_wd got %0h want 0", map_wr_data); else n_pass++; n_chk++;
    if (player_x !== 4'd6) $display("FAIL rst_x got %0d want 6", player_x); else n_pass++; n_chk++;
    if (player_y !== 4'd12) $display("FAIL rst_y got %0d want 12", player_y); else n_pass++; n_chk++;
    if (floor !== 16'd0) $display("FAIL rst_floor got %0d want 0", floor); else n_pass++; n_chk++;
    if (key_num !== 32'd0) $display("FAIL rst_key got %0h want 0", key_num); else n_pass++; n_chk++;
    if (health !== 16'd100) $display("FAIL rst_hp got %0d want 100", health); else n_pass++; n_chk++;
    if (mt_tile_id !== 16'd0) $display("FAIL rst_tile got %0h want 0", mt_tile_id); else n_pass++; n_chk++;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_ground();
    obs_t o;
    exp_t e;
    mem[12'h0B6] = T_GROUND;
    predict(2'd0);
    issue(2'd0, o);
    e = sb.pop_front();
    if (o.lat !== e.lat) $display("FAIL ground_lat got %0d want %0d", o.lat, e.lat); else n_pass++; n_chk++;
    if (o.blk !== e.blk) $display("FAIL ground_blk got %0b want %0b", o.blk, e.blk); else n_pass++; n_chk++;
    if (o.y !== 4'd11) $display("FAIL ground_y got %0d want 11", o.y); else n_pass++; n_chk++;
    if (o.we_cnt !== 0) $display("FAIL ground_we got %0d want 0", o.we_cnt); else n_pass++; n_chk++;
    if (o.rd_addr !== 12'h0B6) $display("FAIL ground_rdaddr got %0h want 0b6", o.rd_addr); else n_pass++; n_chk++;
  endtask

  task automatic test_wall();
    obs_t o;
    exp_t e;
    mem[12'h0A6] = T_WALL;
    predict(2'd0);
    issue(2'd0, o);
    e = sb.pop_front();
    if (o.lat !== e.lat) $display("FAIL wall_lat got %0d want %0d", o.lat, e.lat); else n_pass++; n_chk++;
    if (o.blk !== 1'b1) $display("FAIL wall_blk got %0b want 1", o.blk); else n_pass++; n_chk++;
    if ({o.x, o.y} !== {e.x, e.y}) $display("FAIL wall_pos got %0d,%0d want %0d,%0d", o.x, o.y, e.x, e.y); else n_pass++; n_chk++;
    if (o.we_cnt !== 0) $display("FAIL wall_we got %0d want 0", o.we_cnt); else n_pass++; n_chk++;
    if (o.hp !== 16'd100) $display("FAIL wall_hp got %0d want 100", o.hp); else n_pass++; n_chk++;
  endtask

  task automatic test_key();
    obs_t o;
    exp_t e;
    do_reset();
    mem[12'h0B6] = T_KEY1;
    predict(2'd0);
    issue(2'd0, o);
    e = sb.pop_front();
    if (o.key !== 32'h100) $display("FAIL key_num got %0h want 100", o.key); else n_pass++; n_chk++;
    if (o.blk !== e.blk) $display("FAIL key_blk got %0b want %0b", o.blk, e.blk); else n_pass++; n_chk++;
    if (o.we_cnt !== 1) $display("FAIL key_wecnt got %0d want 1", o.we_cnt); else n_pass++; n_chk++;
    if (o.we !== e.we) $display("FAIL key_we_at_done got %0b want %0b", o.we, e.we); else n_pass++; n_chk++;
    if (o.addr !== 12'h0B6) $display("FAIL key_waddr got %0h want 0b6", o.addr); else n_pass++; n_chk++;
    if (o.wd !== T_GROUND) $display("FAIL key_wdata got %0h want %0h", o.wd, T_GROUND); else n_pass++; n_chk++;
    if (mem[12'h0B6] !== T_GROUND) $display("FAIL key_mem got %0h want %0h", mem[12'h0B6], T_GROUND); else n_pass++; n_chk++;
  endtask

  task automatic test_oob();
    obs_t o;
    exp_t e;
    logic [11:0] a0;
    mem[12'h0B3] = T_TRAP;
    for (int i = 0; i < 6; i++) begin
      predict(2'd2);
      issue(2'd2, o);
      e = sb.pop_front();
      if (o.x !== e.x) $display("FAIL left%0d_x got %0d want %0d", i, o.x, e.x); else n_pass++; n_chk++;
      if (o.hp !== e.hp) $display("FAIL left%0d_hp got %0d want %0d", i, o.hp, e.hp); else n_pass++; n_chk++;
    end
    if (o.hp !== 16'd70) $display("FAIL trap_hp got %0d want 70", o.hp); else n_pass++; n_chk++;
    a0 = map_addr;
    predict(2'd2);
    issue(2'd2, o);
    e = sb.pop_front();
    if (o.lat !== 1) $display("FAIL oob_lat got %0d want 1", o.lat); else n_pass++; n_chk++;
    if (o.blk !== e.blk) $display("FAIL oob_blk got %0b want %0b", o.blk, e.blk); else n_pass++; n_chk++;
    if (o.rd_addr !== a0) $display("FAIL oob_addr got %0h want %0h", o.rd_addr, a0); else n_pass++; n_chk++;
    if (o.we_cnt !== 0) $display("FAIL oob_we got %0d want 0", o.we_cnt); else n_pass++; n_chk++;
    if (o.x !== 4'd0) $display("FAIL oob_x got %0d want 0", o.x); else n_pass++; n_chk++;
  endtask

  task automatic test_stair();
    obs_t o;
    exp_t e;
    do_reset();
    mem[12'h0B6] = T_STAIR1;
    predict(2'd0);
    issue(2'd0, o);
    e = sb.pop_front();
    if (o.fl !== 16'd1) $display("FAIL stair_floor got %0d want 1", o.fl); else n_pass++; n_chk++;
    if ({o.x, o.y} !== {UP_X, UP_Y}) $display("FAIL stair_pos got %0d,%0d want %0d,%0d", o.x, o.y, UP_X, UP_Y); else n_pass++; n_chk++;
    if (o.blk !== e.blk) $display("FAIL stair_blk got %0b want %0b", o.blk, e.blk); else n_pass++; n_chk++;
    if (o.we_cnt !== 0) $display("FAIL stair_we got %0d want 0", o.we_cnt); else n_pass++; n_chk++;
    if (o.lat !== e.lat) $display("FAIL stair_lat got %0d want %0d", o.lat, e.lat); else n_pass++; n_chk++;
  endtask

  task automatic test_back_to_back();
    obs_t o1;
    obs_t o2;
    exp_t e1;
    exp_t e2;
    predict(2'd3);
    issue(2'd3, o1);
    predict(2'd1);
    issue(2'd1, o2);
    e1 = sb.pop_front();
    e2 = sb.pop_front();
    if (o1.x !== e1.x) $display("FAIL b2b_x got %0d want %0d", o1.x, e1.x); else n_pass++; n_chk++;
    if (o2.y !== e2.y) $display("FAIL b2b_y got %0d want %0d", o2.y, e2.y); else n_pass++; n_chk++;
    if (o2.rd_addr !== 12'h154) $display("FAIL b2b_rdaddr got %0h want 154", o2.rd_addr); else n_pass++; n_chk++;
    if (o2.done_cyc - o1.done_cyc !== 5) $display("FAIL b2b_gap got %0d want 5", o2.done_cyc - o1.done_cyc); else n_pass++; n_chk++;
  endtask

  task automatic test_reset_mid();
    obs_t o;
    exp_t e;
    int dn;
    do_reset();
    mem[12'h0B6] = T_KEY0;
    mem[12'h0A6] = T_DOOR0;
    predict(2'd0);
    issue(2'd0, o);
    e = sb.pop_front();
    if (o.key !== 32'd1) $display("FAIL mid_key1 got %0h want 1", o.key); else n_pass++; n_chk++;
    move_dir = 2'd0;
    move_valid = 1'b1;
    @(posedge clk); #1;
    move_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    dn = int'(move_done);
    if (map_we !== 1'b0) $display("FAIL mid_we got %0b want 0", map_we); else n_pass++; n_chk++;
    if (key_num !== 32'd0) $display("FAIL mid_key got %0h want 0", key_num); else n_pass++; n_chk++;
    if (move_ready !== 1'b1) $display("FAIL mid_ready got %0b want 1", move_ready); else n_pass++; n_chk++;
    move_valid = 1'b1;
    @(posedge clk); #1;
    dn += int'(move_done) + int'(map_we);
    rst = 1'b0;
    model_reset();
    predict(2'd0);
    issue(2'd0, o);
    e = sb.pop_front();
    if (dn !== 0) $display("FAIL mid_nodone got %0d want 0", dn); else n_pass++; n_chk++;
    if (o.lat !== e.lat) $display("FAIL mid_lat got %0d want %0d", o.lat, e.lat); else n_pass++; n_chk++;
    if (o.y !== 4'd11) $display("FAIL mid_y got %0d want 11", o.y); else n_pass++; n_chk++;
    if (mem[12'h0A6] !== T_DOOR0) $display("FAIL mid_door got %0h want %0h", mem[12'h0A6], T_DOOR0); else n_pass++; n_chk++;
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = T_GROUND;
    model_reset();
    test_reset();
    test_ground();
    test_wall();
    test_key();
    test_oob();
    test_stair();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1);
  end

endmodule

// File: doc/player_move_ctrl.md
# player_move_ctrl

Sequencer that sits directly upstream of the tile-interaction combinational stage. It accepts one movement command at a time, computes the target cell, and reads that cell's tile ID from the synchronous map RAM. It presents the current game state plus the tile to the interaction stage, captures the resolved results, writes the replacement tile back to the map, and commits the new player state. It owns the architectural game-state registers: position, floor, keys, health.

## Interface
- MAP_W, 13: map width in cells; legal x is 0..MAP_W-1
- MAP_H, 13: map height in cells; legal y is 0..MAP_H-1
- FLOOR_BITS, 4: floor bits used in the map address
- INIT_X, 6 / INIT_Y, 12 / INIT_FLOOR, 0 / INIT_HEALTH, 100: reset values of the game state
- clk  in  1  system clock; all state changes on its rising edge
- rst  in  1  asynchronous, active-high reset
- move_valid  in  1  command request
- move_dir  in  2  0=up (y-1), 1=down (y+1), 2=left (x-1), 3=right (x+1)
- move_ready  out  1  high only in IDLE
- move_done  out  1  one-cycle pulse when a command retires
- move_blocked  out  1  valid with move_done: player did not change cell and did not change floor
- map_addr  out  FLOOR_BITS+8  {floor[FLOOR_BITS-1:0], y, x}
- map_rd_data  in  16  tile ID; valid the cycle after map_addr is driven
- map_we  out  1  write strobe; addresses the latched target cell
- map_wr_data  out  16  replacement tile
- mt_pos_x, mt_pos_y  out  4  target cell, to the interaction stage
- mt_floor  out  16, mt_player_x/y  out  4, mt_key_num  out  32, mt_health  out  16, mt_tile_id  out  16: current state and the latched tile
- mt_floor_out  in  16, mt_goto_x/y  in  4, mt_key_num_out  in  32, mt_health_out  in  16, mt_new_tile_id  in  16: resolved results from the interaction stage
- player_x, player_y  out  4, floor  out  16, key_num  out  32, health  out  16: committed state

## Operation
- States and transitions:
  - IDLE → RD on accept (move_valid & move_ready).
  - RD → LATCH → EVAL → WB → IDLE.
- Accept:
  - Latch move_dir.
  - Compute the target with 5-bit arithmetic.
  - If the target falls outside the map (x<0, x≥MAP_W, y<0, y≥MAP_H), go to IDLE instead of RD. Pulse move_done with move_blocked=1 in the next cycle. No RAM access.
- RD: drive map_addr from the current floor and the target cell. Latch that address into wb_addr.
- LATCH: capture map_rd_data into tile_reg. mt_tile_id is driven from tile_reg.
- EVAL: the interaction stage settles combinationally. Capture all mt_*_out inputs into result registers.
- WB:
  - map_we=1 and map_wr_data=new_tile only if new_tile ≠ tile_reg. The write targets wb_addr, which is the pre-stair floor.
  - Commit the result registers to player_x/y, floor, key_num and health.
  - Pulse move_done.
  - move_blocked = (goto == old position) && (floor_out == old floor).
- The mt_* state outputs always mirror the committed registers and stay stable from RD through WB.
- move_valid outside IDLE is ignored. No queueing.
- The interaction stage's arithmetic results are committed unmodified. No saturation in this block.
- Outputs while idle: map_addr holds its last value, map_we=0, map_wr_data=0.

## Timing
- Reset values:
  - State is IDLE; move_ready=1.
  - move_done=0, move_blocked=0, map_we=0, map_wr_data=0, map_addr=0.
  - player_x=INIT_X, player_y=INIT_Y, floor=INIT_FLOOR, key_num=0, health=INIT_HEALTH.
  - tile_reg=0, and all result registers are 0.
- Latency, accept edge to move_done high:
  - 4 cycles for in-bounds moves (RD, LATCH, EVAL, WB).
  - 1 cycle for out-of-bounds moves.
- Throughput: a new command can be accepted in the cycle after move_done, because move_ready rises with IDLE.
- New state values are visible the cycle move_done is high. map_we is coincident with move_done.
- Reset asserted mid-operation:
  - Immediate return to reset values.
  - Any pending write is dropped; map_we is forced to 0 asynchronously.
  - No move_done pulse.
- A RAM read in RD and a write in WB are never in the same cycle. A single-port RAM is sufficient.

## Test plan
- Reset, then move_dir=0 toward a ground tile at (6,11):
  - move_done 4 cycles after accept, move_blocked=0.
  - player_y=11, map_we never asserted.
- Target tile RS_wall_0:
  - move_done with move_blocked=1, player position unchanged.
  - map_we=0, health unchanged at 100.
- Target tile RS_key_1 at (6,11):
  - key_num=0x00000100 after commit.
  - map_we pulses once at address {0,11,6} with data RS_ground_0.
- Player at x=0, move_dir=2:
  - move_done 1 cycle after accept, move_blocked=1.
  - No map_addr change, no write.
- Target RS_stair_1 from floor 0:
  - floor=1, player moved to the interaction stage's up_x/up_y.
  - move_blocked=0, no write, since the tile is unchanged.
- Assert rst during EVAL of a RS_door_0 move with one key:
  - No map_we, key_num=0 (reset value), state IDLE, move_ready=1 while rst is high.
  - A move_valid held through the cycle after release is accepted.
